preamble_seq: RTL and testbench

- Sequences the legacy 802.11 PLCP preamble for the OFDM TX path.
- On a start pulse it reads the short-preamble ROM and then the long-preamble ROM, SHORT_LEN and LONG_LEN samples respectively.
- Samples go out as one continuous valid/ready stream toward the IQ output mux, and a done pulse hands control to the SIGNAL/DATA symbol path.
- Both ROMs are combinational (address in, data out same cycle) and sit outside this block.

---
 rtl/preamble_seq.sv | 141 ++++++++++++++
 tb/tb_preamble_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preamble_seq.sv
// Legacy 802.11 PLCP preamble sequencer: streams the short then the long preamble ROM
// as one gapless valid/ready stream and pulses done once the final sample is accepted.
module preamble_seq #(
  parameter int SHORT_LEN = 160,
  parameter int LONG_LEN  = 160,
  parameter int ADDR_W    = 8,
  parameter int DW        = 32
) (
  input  logic              clk,
  input  logic              phy_tx_arestn,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] short_addr,
  input  logic [DW-1:0]     short_data,
  output logic [ADDR_W-1:0] long_addr,
  input  logic [DW-1:0]     long_data,
  output logic [DW-1:0]     out_iq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_phase,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SHORT, LONG, DRAIN} state_e;

  localparam logic [ADDR_W-1:0] SHORT_MAX = ADDR_W'(SHORT_LEN - 1);
  localparam logic [ADDR_W-1:0] LONG_MAX  = ADDR_W'(LONG_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]     iq_q, iq_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              phase_q, phase_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load;

  // The output register reloads whenever it is empty or being drained this edge,
  // so the stream stays gapless and no sample is ever dropped or repeated.
  assign load = ((state_q == SHORT) || (state_q == LONG)) && (!valid_q || out_ready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iq_d    = iq_q;
    valid_d = valid_q;
    last_d  = last_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SHORT;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        SHORT: begin
          if (load) begin
            iq_d    = short_data;
            phase_d = 1'b0;
            valid_d = 1'b1;
            if (cnt_q == SHORT_MAX) begin
              state_d = LONG;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + ADDR_W'(1);
            end
          end
        end
        LONG: begin
          if (load) begin
            iq_d    = long_data;
            phase_d = 1'b1;
            valid_d = 1'b1;
            if (cnt_q == LONG_MAX) begin
              last_d  = 1'b1;
              state_d = DRAIN;
            end else begin
              cnt_d = cnt_q + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      iq_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iq_q    <= iq_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign short_addr = (state_q == SHORT) ? cnt_q : '0;
  assign long_addr  = (state_q == LONG)  ? cnt_q : '0;
  assign out_iq     = iq_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign out_phase  = phase_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_preamble_seq.sv
// Directed bench for preamble_seq: bench-side ROM tables feed the DUT and provide
// the expected sample sequence for every scenario.
module tb_preamble_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  short_addr;
  logic [31:0] short_data;
  logic [7:0]  long_addr;
  logic [31:0] long_data;
  logic [31:0] out_iq;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_phase;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] short_rom(input logic [7:0] a);
    return {8'h40, a, a ^ 8'h11, ~a};
  endfunction

  function automatic logic [31:0] long_rom(input logic [7:0] a);
    if (a == 8'd0)   return 32'hEC000000;
    if (a == 8'd159) return 32'hFF580F67;
    return {8'hB0, a, 8'h5A, a ^ 8'hFF};
  endfunction

  function automatic logic [31:0] exp_sample(input int idx);
    if (idx < 160) return short_rom(8'(idx));
    return long_rom(8'(idx - 160));
  endfunction

  assign short_data = short_rom(short_addr);
  assign long_data  = long_rom(long_addr);

  preamble_seq #(
    .SHORT_LEN(160), .LONG_LEN(160), .ADDR_W(8), .DW(32)
  ) dut (
    .clk(clk), .phy_tx_arestn(rst_n), .start(start), .abort(abort),
    .short_addr(short_addr), .short_data(short_data),
    .long_addr(long_addr), .long_data(long_data),
    .out_iq(out_iq), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_phase(out_phase), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({out_iq, out_valid, out_last, out_phase, busy, done, short_addr, long_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_values iq=%h v=%b l=%b p=%b busy=%b done=%b sa=%0d la=%0d, required all 0",
               out_iq, out_valid, out_last, out_phase, busy, done, short_addr, long_addr);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if ({out_valid, busy, done, short_addr, long_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle v=%b busy=%b done=%b sa=%0d la=%0d, required all 0",
               out_valid, busy, done, short_addr, long_addr);
    end
  endtask

  task automatic test_full_stream();
    int idx = 0;
    int cyc = 0;
    bit gap = 0;
    out_ready = 1'b1;
    do_start();
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_after_e0 busy=%b valid=%b, required busy=1 valid=0", busy, out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_iq !== short_rom(8'd0)) begin
      n_fail++;
      $display("FAIL full_first_sample valid=%b iq=%h, required valid=1 iq=%h", out_valid, out_iq, short_rom(8'd0));
    end
    while (idx < 320 && cyc < 1000) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_iq !== exp_sample(idx) || out_phase !== (idx >= 160) || out_last !== (idx == 319) ||
            done !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL full_sample[%0d] iq=%h p=%b l=%b done=%b busy=%b, required iq=%h p=%b l=%b done=0 busy=1",
                   idx, out_iq, out_phase, out_last, done, busy, exp_sample(idx), (idx >= 160), (idx == 319));
        end
        if (idx == 160) begin
          n_checks++;
          if (out_iq !== 32'hEC000000 || out_phase !== 1'b1) begin
            n_fail++;
            $display("FAIL full_long0 iq=%h p=%b, required iq=ec000000 p=1", out_iq, out_phase);
          end
        end
        if (idx == 319) begin
          n_checks++;
          if (out_iq !== 32'hFF580F67 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL full_long159 iq=%h l=%b, required iq=ff580f67 l=1", out_iq, out_last);
          end
        end
        idx++;
      end else begin
        gap = 1'b1;
      end
      step();
      cyc++;
    end
    n_checks++;
    if (idx != 320 || gap) begin
      n_fail++;
      $display("FAIL full_count transfers=%0d gap=%b, required 320 transfers gap=0", idx, gap);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done done=%b busy=%b v=%b l=%b, required done=1 busy=0 v=0 l=0", done, busy, out_valid, out_last);
    end
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done_width done=%b, required 0", done);
    end
  endtask

  task automatic test_random_ready();
    int idx = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [31:0] prev_iq = '0;
    logic prev_phase = 1'b0;
    do_start();
    while (idx < 320 && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_iq !== prev_iq || out_phase !== prev_phase) begin
          n_fail++;
          $display("FAIL rand_stall_hold v=%b iq=%h p=%b, required v=1 iq=%h p=%b",
                   out_valid, out_iq, out_phase, prev_iq, prev_phase);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_iq !== exp_sample(idx) || out_last !== (idx == 319) || done !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_sample[%0d] iq=%h l=%b done=%b, required iq=%h l=%b done=0",
                   idx, out_iq, out_last, done, exp_sample(idx), (idx == 319));
        end
        idx++;
      end
      stalled    = out_valid && !out_ready;
      prev_iq    = out_iq;
      prev_phase = out_phase;
      step();
      cyc++;
    end
    n_checks++;
    if (idx != 320 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_done transfers=%0d done=%b, required 320 transfers done=1", idx, done);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_boundary_stall();
    int idx = 0;
    int cyc = 0;
    bit seen = 0;
    out_ready = 1'b1;
    do_start();
    while (idx < 159 && cyc < 1000) begin
      if (out_valid && out_ready) idx++;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_iq !== short_rom(8'd159) || out_phase !== 1'b0 || long_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL bnd_stall v=%b iq=%h p=%b la=%0d, required v=1 iq=%h p=0 la=0",
               out_valid, out_iq, out_phase, long_addr, short_rom(8'd159));
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_iq !== 32'hEC000000 || out_phase !== 1'b1 || long_addr !== 8'd1) begin
      n_fail++;
      $display("FAIL bnd_release iq=%h p=%b la=%0d, required iq=ec000000 p=1 la=1", out_iq, out_phase, long_addr);
    end
    cyc = 0;
    while (!seen && cyc < 400) begin
      seen = done;
      step();
      cyc++;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bnd_done_timeout seen=%b, required done within 400 cycles", seen);
    end
  endtask

  task automatic test_start_while_busy();
    int idx = 0;
    int cyc = 0;
    int early_done = 0;
    int late = 0;
    bit pulsed = 0;
    out_ready = 1'b1;
    do_start();
    while (idx < 320 && cyc < 1000) begin
      if (idx == 50 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) early_done++;
      if (out_valid && out_ready) idx++;
      step();
      cyc++;
    end
    start = 1'b0;
    n_checks++;
    if (idx != 320 || early_done != 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_len transfers=%0d early_done=%0d done=%b, required 320 0 1", idx, early_done, done);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy || out_valid) late++;
    end
    n_checks++;
    if (late != 0) begin
      n_fail++;
      $display("FAIL busy_start_extra active_cycles=%0d, required 0", late);
    end
  endtask

  task automatic test_abort();
    int idx = 0;
    int cyc = 0;
    out_ready = 1'b1;
    do_start();
    while (idx < 200 && cyc < 1000) begin
      if (out_valid && out_ready) idx++;
      step();
      cyc++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0 || long_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_now v=%b busy=%b done=%b l=%b la=%0d, required all 0", out_valid, busy, done, out_last, long_addr);
    end
    step();
    step();
    n_checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done done=%b v=%b, required 0 0", done, out_valid);
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_with_start busy=%b, required 0", busy);
    end
    do_start();
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_iq !== short_rom(8'd0) || out_phase !== 1'b0 || short_addr !== 8'd1) begin
      n_fail++;
      $display("FAIL abort_restart v=%b iq=%h p=%b sa=%0d, required v=1 iq=%h p=0 sa=1",
               out_valid, out_iq, out_phase, short_addr, short_rom(8'd0));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    int idx = 0;
    int cyc = 0;
    out_ready = 1'b1;
    do_start();
    while (idx < 100 && cyc < 1000) begin
      if (out_valid && out_ready) idx++;
      step();
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_iq, out_valid, out_last, out_phase, busy, done, short_addr, long_addr} !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate iq=%h v=%b l=%b p=%b busy=%b done=%b sa=%0d la=%0d, required all 0",
               out_iq, out_valid, out_last, out_phase, busy, done, short_addr, long_addr);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || short_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL arst_idle v=%b busy=%b done=%b sa=%0d, required all 0", out_valid, busy, done, short_addr);
    end
    do_start();
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_iq !== short_rom(8'd0)) begin
      n_fail++;
      $display("FAIL arst_restart v=%b iq=%h, required v=1 iq=%h", out_valid, out_iq, short_rom(8'd0));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_full_stream();
    test_random_ready();
    test_boundary_stall();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
